koopa_sprite_fetch: RTL

- Initiator side of the Koopa sprite ROM interface: converts the current VGA pixel coordinate into a sprite ROM address and consumes the returned 6-bit colour.
- Tags each output pixel as opaque or transparent for the compositor.
- Owns animation-frame sequencing, horizontal flip, and per-video-frame shadowing of sprite position.
- Sits between the VGA timing generator and the layer mux; drives the 14-bit ROM address bus, reads 6-bit rgb back combinationally.

---
 rtl/koopa_sprite_fetch.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/koopa_sprite_fetch.sv
// Koopa sprite fetch: turns the VGA pixel coordinate into a sprite ROM
// address and tags the returned colour as opaque or transparent.
//
// Ports:
//   clk, rst_n           pixel clock, async active-low reset
//   pix_valid/x/y        current active-video pixel from the timing generator
//   frame_start          one-cycle pulse at the start of every video frame
//   spr_x/spr_y/flip     requested sprite placement (shadowed on frame_start)
//   anim_en              enables animation-frame stepping
//   rom_addr / rom_rgb   sprite ROM address out, colour back (combinational)
//   px_valid/rgb/opaque  pixel result, two cycles after pix_valid
module koopa_sprite_fetch #(
    parameter int          SPR_W       = 30,
    parameter int          SPR_H       = 46,
    parameter int          N_FRAMES    = 3,
    parameter int          FRAME_TICKS = 8,
    parameter logic [5:0]  KEY_RGB     = 6'b110011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        frame_start,
    input  logic [9:0]  spr_x,
    input  logic [9:0]  spr_y,
    input  logic        flip,
    input  logic        anim_en,
    output logic [13:0] rom_addr,
    input  logic [5:0]  rom_rgb,
    output logic        px_valid,
    output logic [5:0]  px_rgb,
    output logic        px_opaque
);

    localparam int FRAME_PIX = SPR_W * SPR_H;
    localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    typedef enum logic {
        HOLD,
        RUN
    } anim_state_e;

    anim_state_e   state_q, state_d;
    logic [FW-1:0] frame_idx_q, frame_idx_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;

    logic [9:0]    sx_q, sy_q;
    logic          sflip_q;

    logic [13:0]   rom_addr_q, rom_addr_d;
    logic          hit_q, hit_d;
    logic          v_q, v_d;

    logic          px_valid_q, px_valid_d;
    logic          px_opaque_q, px_opaque_d;
    logic [5:0]    px_rgb_q, px_rgb_d;

    logic signed [10:0] dx, dy;
    logic               hit;
    logic [9:0]         col;
    logic [13:0]        addr_calc;

    // Shadow copies keep the sprite steady for a whole video frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q    <= '0;
            sy_q    <= '0;
            sflip_q <= 1'b0;
        end else if (frame_start) begin
            sx_q    <= spr_x;
            sy_q    <= spr_y;
            sflip_q <= flip;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            frame_idx_q <= '0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            frame_idx_q <= frame_idx_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_idx_d = frame_idx_q;
        tick_cnt_d  = tick_cnt_q;
        unique case (state_q)
            HOLD: begin
                tick_cnt_d = '0;
                if (frame_start && anim_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (frame_start) begin
                    if (!anim_en) begin
                        state_d    = HOLD;
                        tick_cnt_d = '0;
                    end else if (tick_cnt_q == TW'(FRAME_TICKS - 1)) begin
                        tick_cnt_d  = '0;
                        frame_idx_d = (frame_idx_q == FW'(N_FRAMES - 1))
                                    ? '0 : frame_idx_q + 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // Zero-extend before subtracting so a sprite hanging off the left/top
    // edge gives a negative offset rather than wrapping into a hit.
    assign dx = $signed({1'b0, pix_x}) - $signed({1'b0, sx_q});
    assign dy = $signed({1'b0, pix_y}) - $signed({1'b0, sy_q});

    assign hit = !dx[10] && (dx[9:0] < 10'(SPR_W))
              && !dy[10] && (dy[9:0] < 10'(SPR_H));

    assign col = sflip_q ? 10'(SPR_W - 1) - dx[9:0] : dx[9:0];

    assign addr_calc = 14'(frame_idx_q) * 14'(FRAME_PIX)
                     + 14'(dy[9:0]) * 14'(SPR_W)
                     + 14'(col);

    always_comb begin
        rom_addr_d = rom_addr_q;
        hit_d      = hit_q;
        v_d        = pix_valid;
        if (pix_valid) begin
            rom_addr_d = hit ? addr_calc : '0;
            hit_d      = hit;
        end
    end

    always_comb begin
        px_valid_d  = v_q;
        px_opaque_d = v_q && hit_q && (rom_rgb != KEY_RGB);
        px_rgb_d    = px_opaque_d ? rom_rgb : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q  <= '0;
            hit_q       <= 1'b0;
            v_q         <= 1'b0;
            px_valid_q  <= 1'b0;
            px_opaque_q <= 1'b0;
            px_rgb_q    <= '0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            hit_q       <= hit_d;
            v_q         <= v_d;
            px_valid_q  <= px_valid_d;
            px_opaque_q <= px_opaque_d;
            px_rgb_q    <= px_rgb_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign px_valid  = px_valid_q;
    assign px_opaque = px_opaque_q;
    assign px_rgb    = px_rgb_q;

endmodule
